// File: rtl/mem_responder_if.sv
// Request/response bundle between a memory-strobe initiator and mem_responder.
// The master drives the strobes and request fields; the slave returns data, handshake and error.
interface mem_responder_if;
    logic        read;
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        ready;
    logic        err;

    modport master (
        output read,
        output write,
        output addr,
        output wdata,
        input  rdata,
        input  rdata_valid,
        input  ready,
        input  err
    );

    modport slave (
        input  read,
        input  write,
        input  addr,
        input  wdata,
        output rdata,
        output rdata_valid,
        output ready,
        output err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-strobe bus target: IDLE/WAIT/RESP handshake in front of a synchronous byte RAM.
// Optional MEM_RESP_BOUNDS_EN flags addresses >= DEPTH instead of wrapping them.
module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input logic            clk,
    input logic            reset,
    mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_s;
    logic            accept_s;
    logic            is_write_r;
    logic [AW-1:0]   idx_r;
    logic [7:0]      wdata_r;
    logic            oob_s;
    logic            oob_r;
    logic            mem_we_s;
    logic [7:0]      rdata_r;
    logic            rdata_valid_r;
    logic            ready_r;
    logic            err_r;
    logic            addr_unused_s;
    logic [7:0]      mem_r [DEPTH];

    // A new request is only taken while idle; strobes in any other state are dropped.
    assign accept_s = (state_r == ST_IDLE) && (bus.read || bus.write);

    // Upper address bits only matter to the bounds check; otherwise the access wraps.
    assign addr_unused_s = ^bus.addr;

`ifdef MEM_RESP_BOUNDS_EN
    // Out-of-range decode against the full 16-bit request address.
    always_comb begin
        oob_s = 1'b0;
        if ({1'b0, bus.addr} >= 17'(DEPTH)) begin
            oob_s = 1'b1;
        end else begin
            oob_s = 1'b0;
        end
    end
`else
    assign oob_s = 1'b0;
`endif

    // State register and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; the counter reaching 1 ends the wait phase.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_s = 4'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_RESP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Request capture: address index, write data, operation and range flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_write_r <= 1'b0;
            idx_r      <= '0;
            wdata_r    <= 8'h00;
            oob_r      <= 1'b0;
        end else if (accept_s) begin
            is_write_r <= bus.write;
            idx_r      <= bus.addr[AW-1:0];
            wdata_r    <= bus.wdata;
            oob_r      <= oob_s;
        end else begin
            is_write_r <= is_write_r;
            idx_r      <= idx_r;
            wdata_r    <= wdata_r;
            oob_r      <= oob_r;
        end
    end

    // Writes commit only on the RESP edge; reset forces IDLE so an aborted write never lands.
    always_comb begin
        mem_we_s = 1'b0;
        if ((state_r == ST_RESP) && is_write_r && !oob_r) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

    // Registered response outputs; ready tracks the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r       <= 8'h00;
            rdata_valid_r <= 1'b0;
            ready_r       <= 1'b1;
            err_r         <= 1'b0;
        end else begin
            ready_r <= (state_s == ST_IDLE);
            err_r   <= (state_r == ST_RESP) && oob_r;
            if ((state_r == ST_RESP) && !is_write_r) begin
                rdata_valid_r <= 1'b1;
                rdata_r       <= oob_r ? 8'hFF : mem_r[idx_r];
            end else begin
                rdata_valid_r <= 1'b0;
                rdata_r       <= rdata_r;
            end
        end
    end

    assign bus.rdata       = rdata_r;
    assign bus.rdata_valid = rdata_valid_r;
    assign bus.ready       = ready_r;
`ifdef MEM_RESP_BOUNDS_EN
    assign bus.err         = err_r;
`else
    assign bus.err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder with three wait-state configurations (1, 0, 3)
// checked against a byte-array model and the spec's cycle-count latency rules.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();
    mem_responder_if bus2 ();

    logic        rd_s    [3];
    logic        wr_s    [3];
    logic [15:0] ad_s    [3];
    logic [7:0]  wd_s    [3];
    logic [7:0]  rdat_s  [3];
    logic        valid_s [3];
    logic        rdy_s   [3];
    logic        err_s   [3];

    assign bus0.read = rd_s[0]; assign bus0.write = wr_s[0]; assign bus0.addr = ad_s[0]; assign bus0.wdata = wd_s[0];
    assign bus1.read = rd_s[1]; assign bus1.write = wr_s[1]; assign bus1.addr = ad_s[1]; assign bus1.wdata = wd_s[1];
    assign bus2.read = rd_s[2]; assign bus2.write = wr_s[2]; assign bus2.addr = ad_s[2]; assign bus2.wdata = wd_s[2];
    assign rdat_s[0] = bus0.rdata; assign valid_s[0] = bus0.rdata_valid; assign rdy_s[0] = bus0.ready; assign err_s[0] = bus0.err;
    assign rdat_s[1] = bus1.rdata; assign valid_s[1] = bus1.rdata_valid; assign rdy_s[1] = bus1.ready; assign err_s[1] = bus1.err;
    assign rdat_s[2] = bus2.rdata; assign valid_s[2] = bus2.rdata_valid; assign rdy_s[2] = bus2.ready; assign err_s[2] = bus2.err;

    mem_responder #(.DEPTH(256), .WAIT_STATES(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mem_responder #(.DEPTH(256), .WAIT_STATES(3)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int          n_vec = 0;
    int          n_err = 0;
    int          ws_tab   [3];
    logic [7:0]  mdl_mem  [3][256];
    bit          mdl_known[3][256];
    logic [7:0]  last_rd  [3];
    bit          last_known[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic after_reset_model();
        for (int d = 0; d < 3; d++) begin
            last_rd[d]    = 8'h00;
            last_known[d] = 1'b1;
        end
    endtask

    // One complete access, entered and left on a negedge with the DUT idle.
    // Completion is expected WAIT_STATES+2 negedges after the request is presented.
    task automatic access(input int d, input bit r, input bit w, input logic [15:0] a,
                          input logic [7:0] data, input bit noise);
        bit         oob;
        bit         exp_valid;
        logic [7:0] exp_rd;
        bit         exp_known;
        int         ws;
        ws  = ws_tab[d];
        oob = 1'b0;
`ifdef MEM_RESP_BOUNDS_EN
        oob = (a >= 16'd256);
`endif
        check("ready_before_req", 32'(rdy_s[d]), 32'd1);
        rd_s[d] = r; wr_s[d] = w; ad_s[d] = a; wd_s[d] = data;
        exp_valid = r && !w;
        exp_rd    = last_rd[d];
        exp_known = last_known[d];
        if (exp_valid) begin
            if (oob) begin
                exp_rd = 8'hFF; exp_known = 1'b1;
            end else begin
                exp_rd = mdl_mem[d][a[7:0]]; exp_known = mdl_known[d][a[7:0]];
            end
        end
        if (w && !oob) begin
            mdl_mem[d][a[7:0]]   = data;
            mdl_known[d][a[7:0]] = 1'b1;
        end
        for (int n = 1; n <= ws + 1; n++) begin
            @(negedge clk);
            rd_s[d] = noise && (n % 2 == 1);
            wr_s[d] = 1'b0;
            ad_s[d] = 16'($urandom_range(0, 65535));
            check("ready_busy", 32'(rdy_s[d]), 32'd0);
            check("valid_busy", 32'(valid_s[d]), 32'd0);
            check("err_busy", 32'(err_s[d]), 32'd0);
        end
        @(negedge clk);
        rd_s[d] = 1'b0;
        check("ready_done", 32'(rdy_s[d]), 32'd1);
        check("valid_done", 32'(valid_s[d]), 32'(exp_valid));
        check("err_done", 32'(err_s[d]), 32'(oob));
        if (exp_known) begin
            check("rdata", 32'(rdat_s[d]), 32'(exp_rd));
        end
        last_rd[d]    = exp_rd;
        last_known[d] = exp_known;
    endtask

    initial begin
        ws_tab[0] = 1; ws_tab[1] = 0; ws_tab[2] = 3;
        for (int d = 0; d < 3; d++) begin
            rd_s[d] = 1'b0; wr_s[d] = 1'b0; ad_s[d] = 16'h0000; wd_s[d] = 8'h00;
            for (int i = 0; i < 256; i++) begin
                mdl_mem[d][i] = 8'h00; mdl_known[d][i] = 1'b0;
            end
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_ready", 32'(rdy_s[d]), 32'd1);
            check("rst_rdata", 32'(rdat_s[d]), 32'h00);
            check("rst_valid", 32'(valid_s[d]), 32'd0);
            check("rst_err", 32'(err_s[d]), 32'd0);
        end
        reset = 1'b1;
        after_reset_model();
        @(negedge clk);

        // Reset while the write sits in RESP, before its commit edge.
        rd_s[0] = 1'b0; wr_s[0] = 1'b1; ad_s[0] = 16'h0003; wd_s[0] = 8'h5A;
        @(negedge clk);
        wr_s[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready", 32'(rdy_s[0]), 32'd1);
        check("abort_rdata", 32'(rdat_s[0]), 32'h00);
        @(negedge clk);
        reset = 1'b1;
        after_reset_model();
        @(negedge clk);
        access(0, 1'b1, 1'b0, 16'h0003, 8'h00, 1'b0);
        check("abort_no_commit", 32'(rdat_s[0] == 8'h5A), 32'd0);

        // Directed scenarios.
        access(0, 1'b0, 1'b1, 16'h0010, 8'hA5, 1'b0);
        access(0, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) access(1, 1'b0, 1'b1, 16'(i), 8'(8'h11 * (i + 1)), 1'b0);
        for (int i = 0; i < 3; i++) access(1, 1'b1, 1'b0, 16'(i), 8'h00, 1'b0);
        access(0, 1'b1, 1'b1, 16'h0005, 8'h7E, 1'b0);
        access(0, 1'b1, 1'b0, 16'h0005, 8'h00, 1'b0);
        access(2, 1'b0, 1'b1, 16'h0009, 8'h3C, 1'b0);
        access(2, 1'b1, 1'b0, 16'h0009, 8'h00, 1'b1);
        access(0, 1'b0, 1'b1, 16'h0104, 8'hC3, 1'b0);
        access(0, 1'b1, 1'b0, 16'h0004, 8'h00, 1'b0);
        access(0, 1'b1, 1'b0, 16'h0104, 8'h00, 1'b0);

        // Randomized traffic across all three wait-state settings.
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 40; k++) begin
                int op;
                op = $urandom_range(0, 2);
                access(d, op != 1, op != 0, 16'($urandom_range(0, 511)),
                       8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end
            @(negedge clk);
            check("idle_valid", 32'(valid_s[d]), 32'd0);
            check("idle_ready", 32'(rdy_s[d]), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
